// File: rtl/tour_cmd.sv
// Tour sequencer: walks the solved knight's tour, splitting each one-hot L-move
// into a vertical then a horizontal command for cmd_proc; passes UART commands through when idle.
module tour_cmd #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    // state  | meaning
    // IDLE   | UART commands pass straight through to cmd_proc
    // VERT   | vertical half of the current move offered to cmd_proc
    // WAIT_V | vertical command accepted, waiting for it to finish
    // HORZ   | horizontal half of the current move offered to cmd_proc
    // WAIT_H | horizontal command accepted, waiting for it to finish
    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);
    localparam logic [7:0] HEAD_N    = 8'h00;
    localparam logic [7:0] HEAD_W    = 8'h3F;
    localparam logic [7:0] HEAD_S    = 8'h7F;
    localparam logic [7:0] HEAD_E    = 8'hBF;
    localparam logic [3:0] OP_MOVE   = 4'b0010;
    localparam logic [3:0] OP_FANF   = 4'b0011;
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_ACK  = 8'h5A;

    state_t      state, state_nxt;
    logic [4:0]  mv_indx_nxt;
    logic [7:0]  v_head, h_head;
    logic [3:0]  v_sq, h_sq;
    logic [15:0] v_cmd, h_cmd;
    logic        last_move;

    // Lowest set bit wins; an all-zero move falls through to N/0 and E/0.
    always_comb begin
        v_head = HEAD_N;
        v_sq   = 4'd0;
        h_head = HEAD_E;
        h_sq   = 4'd0;
        if (move[0]) begin
            v_sq = 4'd2;  h_sq = 4'd1;
        end else if (move[1]) begin
            v_sq = 4'd2;  h_head = HEAD_W; h_sq = 4'd1;
        end else if (move[2]) begin
            v_sq = 4'd1;  h_head = HEAD_W; h_sq = 4'd2;
        end else if (move[3]) begin
            v_head = HEAD_S; v_sq = 4'd1; h_head = HEAD_W; h_sq = 4'd2;
        end else if (move[4]) begin
            v_head = HEAD_S; v_sq = 4'd2; h_head = HEAD_W; h_sq = 4'd1;
        end else if (move[5]) begin
            v_head = HEAD_S; v_sq = 4'd2; h_sq = 4'd1;
        end else if (move[6]) begin
            v_head = HEAD_S; v_sq = 4'd1; h_sq = 4'd2;
        end else if (move[7]) begin
            v_sq = 4'd1;  h_sq = 4'd2;
        end
    end

    assign v_cmd     = {OP_MOVE, v_head, v_sq};
    assign h_cmd     = {OP_FANF, h_head, h_sq};
    assign last_move = (mv_indx == LAST_INDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= 5'd0;
        end else begin
            state   <= state_nxt;
            mv_indx <= mv_indx_nxt;
        end
    end

    // clr_cmd_rdy is checked only in the offer states, so a simultaneous send_resp there is dropped.
    always_comb begin
        state_nxt   = state;
        mv_indx_nxt = mv_indx;
        cmd         = v_cmd;
        cmd_rdy     = 1'b0;
        resp        = RESP_ACK;
        case (state)
            IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_DONE;
                if (start_tour) begin
                    mv_indx_nxt = 5'd0;
                    state_nxt   = VERT;
                end
            end
            VERT: begin
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_nxt = WAIT_V;
            end
            WAIT_V: begin
                if (send_resp) state_nxt = HORZ;
            end
            HORZ: begin
                cmd     = h_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_nxt = WAIT_H;
            end
            WAIT_H: begin
                cmd = h_cmd;
                if (last_move) resp = RESP_DONE;
                if (send_resp) begin
                    if (last_move) begin
                        state_nxt = IDLE;
                    end else begin
                        mv_indx_nxt = mv_indx + 5'd1;
                        state_nxt   = VERT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Scoreboard bench for tour_cmd: stimulus queues expected commands/responses,
// a negedge monitor pops and compares on each accepted command and each send_resp.
module tb_tour_cmd;
    localparam int NUM_MOVES = 24;

    // Hand-decoded (vertical, horizontal) command for each one-hot move bit.
    localparam logic [15:0] V_TBL [8] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1,
                                          16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
    localparam logic [15:0] H_TBL [8] = '{16'h3BF1, 16'h33F1, 16'h33F2, 16'h33F2,
                                          16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h1357;
    logic        cmd_rdy_UART = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;

    int n_checks = 0;
    int n_fail = 0;
    int n_acc = 0;
    int acc0;
    logic [15:0] exp_cmd_q [$];
    logic [7:0]  exp_resp_q [$];
    logic [7:0]  tour_mv [NUM_MOVES];

    tour_cmd #(.NUM_MOVES(NUM_MOVES)) dut (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
        .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .resp(resp)
    );

    always #5 clk = ~clk;

    // TourLogic stand-in: move table read combinationally at mv_indx.
    always_comb move = (int'(mv_indx) < NUM_MOVES) ? tour_mv[mv_indx] : 8'h00;

    function automatic logic [15:0] exp_v(input logic [7:0] m);
        for (int b = 0; b < 8; b++) if (m[b]) return V_TBL[b];
        return 16'h2000;
    endfunction

    function automatic logic [15:0] exp_h(input logic [7:0] m);
        for (int b = 0; b < 8; b++) if (m[b]) return H_TBL[b];
        return 16'h3BF0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a command is presented when cmd_rdy meets clr_cmd_rdy; resp is sampled on a lone send_resp.
    initial forever begin
        @(negedge clk);
        if (rst_n && cmd_rdy && clr_cmd_rdy) begin
            n_acc++;
            if (exp_cmd_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb_cmd: got %0h expected no command", cmd);
            end else check("sb_cmd", cmd, exp_cmd_q.pop_front());
        end
        if (rst_n && send_resp && !clr_cmd_rdy) begin
            if (exp_resp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb_resp: got %0h expected no response", resp);
            end else check("sb_resp", resp, exp_resp_q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic wait_rdy(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (cmd_rdy) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: cmd_rdy got 0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_tour = 1'b1;
        @(posedge clk); #1 start_tour = 1'b0;
    endtask

    // cmd_proc model for one command; both=1 raises send_resp together with clr_cmd_rdy.
    task automatic issue(input string name, input logic [15:0] ec, input logic [7:0] er, input bit both);
        exp_cmd_q.push_back(ec);
        exp_resp_q.push_back(er);
        wait_rdy(name);
        @(posedge clk); #1 clr_cmd_rdy = 1'b1; send_resp = both;
        @(posedge clk); #1 clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        @(negedge clk);
        check($sformatf("%s_wait_rdy", name), cmd_rdy, 1'b0);
        @(posedge clk); #1 send_resp = 1'b1;
        @(posedge clk); #1 send_resp = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NUM_MOVES; i++) tour_mv[i] = 8'(1 << (i % 8));
        tour_mv[8]  = 8'h00;
        tour_mv[9]  = 8'h0C;
        tour_mv[10] = 8'hF0;
        tour_mv[17] = 8'h81;

        repeat (2) @(posedge clk);
        #1;
        check("rst_mv_indx", mv_indx, 0);
        check("rst_resp", resp, 8'hA5);
        check("rst_cmd", cmd, 16'h1357);
        check("rst_cmd_rdy", cmd_rdy, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Idle pass-through.
        cmd_UART = 16'h4000; cmd_rdy_UART = 1'b1;
        exp_cmd_q.push_back(16'h4000);
        exp_resp_q.push_back(8'hA5);
        @(negedge clk);
        check("idle_cmd", cmd, 16'h4000);
        check("idle_cmd_rdy", cmd_rdy, 1'b1);
        check("idle_resp", resp, 8'hA5);
        @(posedge clk); #1 clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0; send_resp = 1'b1;
        @(posedge clk); #1 send_resp = 1'b0;

        // Full tour with a blocked UART command pending throughout.
        acc0 = n_acc;
        pulse_start();
        @(negedge clk);
        check("start_latency", cmd_rdy, 1'b1);
        check("first_cmd", cmd, 16'h2002);
        cmd_UART = 16'hDEAD; cmd_rdy_UART = 1'b1;
        for (int i = 0; i < NUM_MOVES; i++) begin
            check($sformatf("mv_indx_%0d", i), mv_indx, i);
            if (i == NUM_MOVES - 1) cmd_rdy_UART = 1'b0;
            issue($sformatf("vert_%0d", i), exp_v(tour_mv[i]), 8'h5A, i == 3);
            if (i == 12) begin
                pulse_start();
                check("mv_indx_hold", mv_indx, 12);
            end
            issue($sformatf("horz_%0d", i), exp_h(tour_mv[i]),
                  (i == NUM_MOVES - 1) ? 8'hA5 : 8'h5A, i == 5);
        end
        @(negedge clk);
        check("end_idle_resp", resp, 8'hA5);
        check("end_idle_cmd_rdy", cmd_rdy, 1'b0);
        check("cmd_count", n_acc - acc0, 48);

        // Reset mid-tour in HORZ at move 7.
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            issue("r_vert", exp_v(tour_mv[i]), 8'h5A, 1'b0);
            issue("r_horz", exp_h(tour_mv[i]), 8'h5A, 1'b0);
        end
        issue("r_vert7", exp_v(tour_mv[7]), 8'h5A, 1'b0);
        wait_rdy("r_horz7");
        check("r_mv_indx7", mv_indx, 7);
        @(posedge clk); #1 rst_n = 1'b0; cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
        #1;
        check("mid_rst_mv_indx", mv_indx, 0);
        check("mid_rst_resp", resp, 8'hA5);
        check("mid_rst_cmd", cmd, 16'h1234);
        check("mid_rst_cmd_rdy", cmd_rdy, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1; cmd_rdy_UART = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_rdy", cmd_rdy, 1'b0);

        pulse_start();
        check("restart_mv_indx", mv_indx, 0);
        issue("rs_vert", exp_v(tour_mv[0]), 8'h5A, 1'b0);
        issue("rs_horz", exp_h(tour_mv[0]), 8'h5A, 1'b0);
        check("restart_mv_indx1", mv_indx, 1);

        repeat (2) @(negedge clk);
        check("sb_cmd_left", exp_cmd_q.size(), 0);
        check("sb_resp_left", exp_resp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
